// File: rtl/gmii_tx_arbiter.sv
// gmii_tx_arbiter: two-source round-robin arbiter onto a single GMII transmit
// stream. One frame per grant, a fixed inter-frame gap, and every output is
// registered. The output is the granted source's stream delayed by one cycle.
// Optional build macro: GMII_TX_ARBITER_WATCHDOG_EN adds a start watchdog
// (grant revoked if tx_en never comes) and a frame-length watchdog (a frame
// that runs too long is cut and its last beat is marked with tx_er).
`timescale 1ns/1ps
module gmii_tx_arbiter #(
    parameter int IFG_CYCLES    = 12,
    parameter int START_TIMEOUT = 16,
    parameter int MAX_FRAME     = 2048
) (
    input  logic       gmii_txc,
    input  logic       rst_n,
    input  logic       link_up,
    input  logic       src0_req,
    input  logic       src1_req,
    output logic       src0_grant,
    output logic       src1_grant,
    input  logic       src0_tx_en,
    input  logic       src0_tx_er,
    input  logic [7:0] src0_txd,
    input  logic       src1_tx_en,
    input  logic       src1_tx_er,
    input  logic [7:0] src1_txd,
    output logic       gmii_tx_en,
    output logic       gmii_tx_er,
    output logic [7:0] gmii_txd
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_GRANT_WAIT = 2'd1,
        S_SEND       = 2'd2,
        S_IFG        = 2'd3
    } state_t;

    localparam int     IFG_W     = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES);
    // With a zero gap a finished frame goes straight back to arbitration.
    localparam state_t END_STATE = (IFG_CYCLES == 0) ? S_IDLE : S_IFG;

    state_t           state_q, state_d;
    logic [IFG_W-1:0] ifg_cnt_q, ifg_cnt_d;
    logic [1:0]       grant_q, grant_d;
    logic             sel_q, sel_d;         // index of the granted source
    logic             last_q, last_d;       // index of the source served last
    logic             gmii_tx_en_q, gmii_tx_en_d;
    logic             gmii_tx_er_q, gmii_tx_er_d;
    logic [7:0]       gmii_txd_q, gmii_txd_d;

    // Granted-source view; the other source's stream never reaches the output.
    logic       sel_req, sel_tx_en, sel_tx_er;
    logic [7:0] sel_txd;
    assign sel_req   = sel_q ? src1_req   : src0_req;
    assign sel_tx_en = sel_q ? src1_tx_en : src0_tx_en;
    assign sel_tx_er = sel_q ? src1_tx_er : src0_tx_er;
    assign sel_txd   = sel_q ? src1_txd   : src0_txd;

    // Round robin on a tie, otherwise whoever is asking.
    logic any_req, pick;
    assign any_req = src0_req | src1_req;
    assign pick    = (src0_req && src1_req) ? ~last_q : src1_req;

    // Cycle events shared by the next-state and output logic.
    logic do_grant, start_beat, revoke, send_beat, send_end, fwd;
    logic start_trip, len_trip, frame_done;
    assign do_grant   = (state_q == S_IDLE) && link_up && any_req;
    assign start_beat = (state_q == S_GRANT_WAIT) && sel_tx_en;
    // A beat arriving together with a dropped request still starts the frame.
    assign revoke     = (state_q == S_GRANT_WAIT) && !sel_tx_en && (!sel_req || !link_up);
    assign send_beat  = (state_q == S_SEND) && sel_tx_en;
    assign send_end   = (state_q == S_SEND) && !sel_tx_en;
    assign fwd        = start_beat | send_beat;
    assign frame_done = send_end | len_trip;

`ifdef GMII_TX_ARBITER_WATCHDOG_EN
    localparam int ST_W = (START_TIMEOUT < 2) ? 1 : $clog2(START_TIMEOUT);
    localparam int FR_W = (MAX_FRAME < 2) ? 1 : $clog2(MAX_FRAME);

    logic [ST_W-1:0] wait_cnt_q, wait_cnt_d;   // cycles already spent in GRANT_WAIT
    logic [FR_W-1:0] beat_cnt_q, beat_cnt_d;   // beats already forwarded this frame

    assign start_trip = (state_q == S_GRANT_WAIT) && !sel_tx_en && !revoke &&
                        (wait_cnt_q == ST_W'(START_TIMEOUT - 1));
    assign len_trip   = fwd && (beat_cnt_q == FR_W'(MAX_FRAME - 1));

    // Watchdog counters restart whenever their state is (re)entered.
    always_comb begin
        wait_cnt_d = '0;
        beat_cnt_d = '0;
        if ((state_q == S_GRANT_WAIT) && (state_d == S_GRANT_WAIT)) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        if (state_d == S_SEND) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    // Watchdog counter registers.
    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            beat_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    assign start_trip = 1'b0;
    assign len_trip   = 1'b0;
    // Watchdog parameters only shape the watchdog build; nothing is built here.
    if ((START_TIMEOUT < 1) || (MAX_FRAME < 1)) begin : g_wd_cfg_unused
    end
`endif

    // State register and all registered outputs.
    always_ff @(posedge gmii_txc or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ifg_cnt_q    <= '0;
            grant_q      <= 2'b00;
            sel_q        <= 1'b0;
            last_q       <= 1'b1;      // src0 wins the first tie
            gmii_tx_en_q <= 1'b0;
            gmii_tx_er_q <= 1'b0;
            gmii_txd_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            ifg_cnt_q    <= ifg_cnt_d;
            grant_q      <= grant_d;
            sel_q        <= sel_d;
            last_q       <= last_d;
            gmii_tx_en_q <= gmii_tx_en_d;
            gmii_tx_er_q <= gmii_tx_er_d;
            gmii_txd_q   <= gmii_txd_d;
        end
    end

    // Next-state logic and inter-frame gap counter.
    always_comb begin
        state_d   = state_q;
        ifg_cnt_d = '0;
        case (state_q)
            S_IDLE: begin
                if (do_grant) begin
                    state_d = S_GRANT_WAIT;
                end
            end
            S_GRANT_WAIT: begin
                if (len_trip) begin
                    state_d = END_STATE;
                end else if (start_beat) begin
                    state_d = S_SEND;
                end else if (revoke || start_trip) begin
                    state_d = S_IDLE;
                end
            end
            S_SEND: begin
                // link_up is deliberately not looked at: a frame always completes.
                if (frame_done) begin
                    state_d = END_STATE;
                end
            end
            S_IFG: begin
                if (ifg_cnt_q == IFG_W'(IFG_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    ifg_cnt_d = ifg_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: grant bookkeeping and the one-cycle forwarding path.
    always_comb begin
        grant_d      = grant_q;
        sel_d        = sel_q;
        last_d       = last_q;
        gmii_tx_en_d = 1'b0;
        gmii_tx_er_d = 1'b0;
        gmii_txd_d   = 8'h00;
        if (do_grant) begin
            sel_d   = pick;
            grant_d = pick ? 2'b10 : 2'b01;
        end
        // A plain revoke leaves the round-robin history untouched.
        if (revoke) begin
            grant_d = 2'b00;
        end
        if (start_trip || frame_done) begin
            grant_d = 2'b00;
            last_d  = sel_q;
        end
        if (fwd) begin
            gmii_tx_en_d = 1'b1;
            gmii_tx_er_d = sel_tx_er | len_trip;
            gmii_txd_d   = sel_txd;
        end
    end

    assign src0_grant = grant_q[0];
    assign src1_grant = grant_q[1];
    assign gmii_tx_en = gmii_tx_en_q;
    assign gmii_tx_er = gmii_tx_er_q;
    assign gmii_txd   = gmii_txd_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter (default parameters). Inputs change 1 ns
// after a rising edge; outputs are checked at that same point, so each check
// sees the registers loaded by the edge just passed.
`timescale 1ns/1ps
module tb_gmii_tx_arbiter;

    logic       gmii_txc = 1'b0;
    logic       rst_n;
    logic       link_up;
    logic       src0_req, src1_req;
    logic       src0_grant, src1_grant;
    logic       src0_tx_en, src0_tx_er, src1_tx_en, src1_tx_er;
    logic [7:0] src0_txd, src1_txd;
    logic       gmii_tx_en, gmii_tx_er;
    logic [7:0] gmii_txd;

    int vectors     = 0;
    int miscompares = 0;

    always #5 gmii_txc = ~gmii_txc;

    gmii_tx_arbiter dut (
        .gmii_txc   (gmii_txc),
        .rst_n      (rst_n),
        .link_up    (link_up),
        .src0_req   (src0_req),
        .src1_req   (src1_req),
        .src0_grant (src0_grant),
        .src1_grant (src1_grant),
        .src0_tx_en (src0_tx_en),
        .src0_tx_er (src0_tx_er),
        .src0_txd   (src0_txd),
        .src1_tx_en (src1_tx_en),
        .src1_tx_er (src1_tx_er),
        .src1_txd   (src1_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_tx_er (gmii_tx_er),
        .gmii_txd   (gmii_txd)
    );

    task automatic step();
        @(posedge gmii_txc);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic eg0, input logic eg1,
                              input logic een, input logic eer, input logic [7:0] ed);
        check({tag, ".grant0"}, 32'(src0_grant), 32'(eg0));
        check({tag, ".grant1"}, 32'(src1_grant), 32'(eg1));
        check({tag, ".tx_en"},  32'(gmii_tx_en), 32'(een));
        check({tag, ".tx_er"},  32'(gmii_tx_er), 32'(eer));
        check({tag, ".txd"},    32'(gmii_txd),   32'(ed));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not reach its summary");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n = 1'b0; link_up = 1'b0; src0_req = 1'b0; src1_req = 1'b0;
        src0_tx_en = 1'b0; src0_tx_er = 1'b0; src0_txd = 8'h00;
        src1_tx_en = 1'b0; src1_tx_er = 1'b0; src1_txd = 8'h00;

        // Reset state, before any clock edge and while held.
        #1;
        expect_out("reset_async", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step(); step();
        expect_out("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Tie from reset: src0 wins on the first edge after release.
        link_up = 1'b1; src0_req = 1'b1; src1_req = 1'b1;
        rst_n = 1'b1;
        step();
        expect_out("tie_after_reset", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("reset released, src0 granted on first tie");

        // 64-byte src0 frame; src1 drives junk that must be ignored.
        src1_tx_en = 1'b1; src1_txd = 8'hEE; src1_tx_er = 1'b1;
        for (int i = 0; i < 64; i++) begin
            src0_tx_en = 1'b1; src0_txd = 8'(i);
            step();
            expect_out("src0_frame", 1'b1, 1'b0, 1'b1, 1'b0, 8'(i));
        end
        src0_tx_en = 1'b0; src0_txd = 8'h00;
        src1_tx_en = 1'b0; src1_txd = 8'h00; src1_tx_er = 1'b0;
        step();
        expect_out("src0_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("src0 64-byte frame forwarded");
        // 12 gap cycles, then IDLE for one cycle, then src1 holds the grant.
        for (int k = 0; k < 12; k++) begin
            step();
            expect_out("ifg_gap", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        step();
        expect_out("rr_src1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        $display("gap done, src1 granted by round robin");

        // src1 sends 55 D5 AA with tx_er on the middle beat; src0 junk ignored.
        src0_tx_en = 1'b1; src0_txd = 8'hFF; src0_tx_er = 1'b1;
        src1_tx_en = 1'b1; src1_txd = 8'h55; src1_tx_er = 1'b0;
        step();
        expect_out("s1_b55", 1'b0, 1'b1, 1'b1, 1'b0, 8'h55);
        src1_txd = 8'hD5; src1_tx_er = 1'b1;
        step();
        expect_out("s1_bD5", 1'b0, 1'b1, 1'b1, 1'b1, 8'hD5);
        src1_txd = 8'hAA; src1_tx_er = 1'b0;
        step();
        expect_out("s1_bAA", 1'b0, 1'b1, 1'b1, 1'b0, 8'hAA);
        src1_tx_en = 1'b0; src1_txd = 8'h00; src1_req = 1'b0;
        src0_tx_en = 1'b0; src0_txd = 8'h00; src0_tx_er = 1'b0;
        step();
        expect_out("s1_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("src1 frame 55 D5 AA forwarded");

        // Link down with src0 requesting: no grant, even after the gap ends.
        link_up = 1'b0;
        for (int k = 0; k < 14; k++) begin
            step();
            expect_out("link_down_idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        link_up = 1'b1;
        step();
        expect_out("link_up_grant", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        // link_up falls after the third beat; the frame still completes.
        for (int i = 0; i < 8; i++) begin
            src0_tx_en = 1'b1; src0_txd = 8'hA0 + 8'(i); link_up = (i < 3);
            step();
            expect_out("link_drop_frame", 1'b1, 1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i));
        end
        src0_tx_en = 1'b0; src0_txd = 8'h00;
        step();
        expect_out("link_drop_end", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("link gating and mid-frame link loss handled");

        // Lone src0 granted again; it drops req before tx_en, src1 pending.
        link_up = 1'b1; src1_req = 1'b0;
        for (int k = 0; k < 20 && src0_grant !== 1'b1; k++) step();
        expect_out("lone_src0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        src0_req = 1'b0; src1_req = 1'b1;
        step();
        expect_out("req_drop_revoke", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        expect_out("pending_src1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        link_up = 1'b0;
        step();
        expect_out("link_revoke", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        link_up = 1'b1;
        step();
        expect_out("regrant_src1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        $display("grant revocations returned to IDLE without a gap");

        // Reset in the middle of a src1 frame.
        src1_tx_en = 1'b1; src1_txd = 8'h11;
        step();
        expect_out("pre_reset_b11", 1'b0, 1'b1, 1'b1, 1'b0, 8'h11);
        src1_txd = 8'h22;
        step();
        expect_out("pre_reset_b22", 1'b0, 1'b1, 1'b1, 1'b0, 8'h22);
        #2;
        rst_n = 1'b0;
        #1;
        expect_out("reset_midframe", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        src1_tx_en = 1'b0; src1_txd = 8'h00;
        src0_req = 1'b1; src1_req = 1'b1; link_up = 1'b1;
        step(); step();
        expect_out("reset_hold2", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        rst_n = 1'b1;
        step();
        expect_out("tie_after_rerelease", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        $display("mid-frame reset truncated output, src0 won the tie after release");

`ifdef GMII_TX_ARBITER_WATCHDOG_EN
        // Start watchdog: src0 holds its grant for 16 cycles without tx_en.
        for (int k = 1; k < 16; k++) begin
            step();
            expect_out("wd_start_hold", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        step();
        expect_out("wd_start_trip", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        step();
        expect_out("wd_rr_src1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        // Length watchdog: beat 2048 carries tx_er and ends the frame.
        for (int i = 0; i < 2048; i++) begin
            src1_tx_en = 1'b1; src1_txd = 8'(i);
            step();
            expect_out("wd_long_frame", 1'b0, (i != 2047), 1'b1, (i == 2047), 8'(i));
        end
        for (int k = 0; k < 12; k++) begin
            step();
            expect_out("wd_discard", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        end
        src1_tx_en = 1'b0; src1_txd = 8'h00;
        $display("start and length watchdogs tripped");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
